// File: rtl/conditioner_pkg.sv
// Shared definitions for the input/output conditioner pair: FSM state encoding and
// default hold-window sizing.
package conditioner_pkg;

    typedef logic cond_state_t;

    localparam cond_state_t IDLE = 1'b0;
    localparam cond_state_t HOLD = 1'b1;

    localparam int DEFAULT_HOLDTIME     = 2;
    localparam int DEFAULT_COUNTERWIDTH = 3;

endpackage

// File: rtl/hold_timer.sv
// Down-counter for the output dwell window: load a start value, count down to zero,
// flag zero. Never decrements below zero.
module hold_timer
    import conditioner_pkg::*;
#(
    parameter int counterwidth = DEFAULT_COUNTERWIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [counterwidth-1:0] load_value,
    input  logic                    decrement,
    output logic                    zero
);

    logic [counterwidth-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (decrement && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/output_conditioner.sv
// Turns 1-clk set/clear request pulses into a glitch-free level with a minimum dwell time,
// deferring requests seen during the dwell in a latest-wins slot. OUTCOND_DROPCOUNT_EN
// adds a saturating count of overwritten deferred requests on droppedcount.
module output_conditioner
    import conditioner_pkg::*;
#(
    parameter int   counterwidth = DEFAULT_COUNTERWIDTH,
    parameter int   holdtime     = DEFAULT_HOLDTIME,
    parameter logic resetlevel   = 1'b0,
    parameter int   dropwidth    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic setpulse,
    input  logic clearpulse,
    output logic conditioned,
    output logic busy,
    output logic pendingvalid,
    output logic conflict
`ifdef OUTCOND_DROPCOUNT_EN
    ,
    output logic [dropwidth-1:0] droppedcount
`endif
);

    localparam logic [counterwidth-1:0] HOLD_RELOAD = counterwidth'(holdtime - 1);

    cond_state_t state;
    cond_state_t state_next;

    logic req;
    logic reqlevel;
    logic pendinglevel;
    logic timer_zero;

    logic apply;
    logic apply_level;
    logic pend_write;
    logic pend_clear;
    logic drop_event;
    logic eff_valid;
    logic eff_level;

    // Both pulses high cancel each other out; the cancellation is reported via conflict.
    assign req       = setpulse ^ clearpulse;
    assign reqlevel  = setpulse;
    assign eff_valid = req | pendingvalid;
    assign eff_level = req ? reqlevel : pendinglevel;

    hold_timer #(
        .counterwidth (counterwidth)
    ) u_hold_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (apply),
        .load_value (HOLD_RELOAD),
        .decrement  (state == HOLD),
        .zero       (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        apply       = 1'b0;
        apply_level = reqlevel;
        pend_write  = 1'b0;
        pend_clear  = 1'b0;
        drop_event  = 1'b0;
        case (state)
            IDLE: begin
                if (req && (reqlevel != conditioned)) begin
                    apply      = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!timer_zero) begin
                    pend_write = req;
                    drop_event = req & pendingvalid;
                end else begin
                    // Expiry cycle: a fresh request takes precedence over the stored one.
                    pend_clear  = 1'b1;
                    drop_event  = req & pendingvalid;
                    apply_level = eff_level;
                    if (eff_valid && (eff_level != conditioned)) begin
                        apply = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            conditioned  <= resetlevel;
            pendingvalid <= 1'b0;
            pendinglevel <= 1'b0;
            conflict     <= 1'b0;
        end else begin
            conflict <= setpulse & clearpulse;
            if (apply) begin
                conditioned <= apply_level;
            end
            if (pend_write) begin
                pendingvalid <= 1'b1;
                pendinglevel <= reqlevel;
            end else if (pend_clear) begin
                pendingvalid <= 1'b0;
            end
        end
    end

`ifdef OUTCOND_DROPCOUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            droppedcount <= '0;
        end else if (drop_event && (droppedcount != '1)) begin
            droppedcount <= droppedcount + 1'b1;
        end
    end
`else
    logic [dropwidth-1:0] drop_unused;
    assign drop_unused = {dropwidth{drop_event}};
`endif

endmodule

// File: tb/tb_output_conditioner.sv
// Directed bench for output_conditioner: a vector table on a holdtime=2 instance, plus
// hand-written sequences for holdtime=1 toggling and (with OUTCOND_DROPCOUNT_EN) saturation.
module tb_output_conditioner;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic a_set = 1'b0, a_clr = 1'b0;
    logic b_set = 1'b0, b_clr = 1'b0;
    logic a_cond, a_busy, a_pend, a_conf;
    logic b_cond, b_busy, b_pend, b_conf;
`ifdef OUTCOND_DROPCOUNT_EN
    logic c_set = 1'b0, c_clr = 1'b0;
    logic c_cond, c_busy, c_pend, c_conf;
    logic [7:0] a_drop;
    logic [1:0] b_drop;
    logic [1:0] c_drop;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    output_conditioner #(
        .counterwidth (3), .holdtime (2), .resetlevel (1'b0), .dropwidth (8)
    ) dut_a (
        .clk (clk), .reset (reset), .setpulse (a_set), .clearpulse (a_clr),
        .conditioned (a_cond), .busy (a_busy), .pendingvalid (a_pend), .conflict (a_conf)
`ifdef OUTCOND_DROPCOUNT_EN
        , .droppedcount (a_drop)
`endif
    );

    output_conditioner #(
        .counterwidth (3), .holdtime (1), .resetlevel (1'b0), .dropwidth (2)
    ) dut_b (
        .clk (clk), .reset (reset), .setpulse (b_set), .clearpulse (b_clr),
        .conditioned (b_cond), .busy (b_busy), .pendingvalid (b_pend), .conflict (b_conf)
`ifdef OUTCOND_DROPCOUNT_EN
        , .droppedcount (b_drop)
`endif
    );

`ifdef OUTCOND_DROPCOUNT_EN
    output_conditioner #(
        .counterwidth (3), .holdtime (4), .resetlevel (1'b0), .dropwidth (2)
    ) dut_c (
        .clk (clk), .reset (reset), .setpulse (c_set), .clearpulse (c_clr),
        .conditioned (c_cond), .busy (c_busy), .pendingvalid (c_pend), .conflict (c_conf),
        .droppedcount (c_drop)
    );
`endif

    typedef struct {
        logic       set;
        logic       clr;
        logic       rst;
        logic       cond;
        logic       busy;
        logic       pend;
        logic       conf;
        logic [7:0] drop;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic s, input logic c, input logic r,
                                input logic ec, input logic eb, input logic ep,
                                input logic ef, input logic [7:0] ed);
        vec_t v;
        v.set = s; v.clr = c; v.rst = r;
        v.cond = ec; v.busy = eb; v.pend = ep; v.conf = ef; v.drop = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            set clr rst  cond busy pend conf drop
        vecs[0]  = mk(0, 0, 1,  0, 0, 0, 0, 0);  // reset state
        vecs[1]  = mk(1, 0, 0,  1, 1, 0, 0, 0);  // set -> level 1, hold starts
        vecs[2]  = mk(0, 0, 0,  1, 1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0,  1, 0, 0, 0, 0);  // back to idle
        vecs[4]  = mk(0, 0, 1,  0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 0, 0,  1, 1, 0, 0, 0);  // set, then clear deferred
        vecs[6]  = mk(0, 1, 0,  1, 1, 1, 0, 0);
        vecs[7]  = mk(0, 0, 0,  0, 1, 0, 0, 0);  // pending applied at expiry
        vecs[8]  = mk(0, 0, 0,  0, 1, 0, 0, 0);
        vecs[9]  = mk(0, 0, 0,  0, 0, 0, 0, 0);
        vecs[10] = mk(1, 0, 0,  1, 1, 0, 0, 0);  // set, clear, set: latest wins
        vecs[11] = mk(0, 1, 0,  1, 1, 1, 0, 0);
        vecs[12] = mk(1, 0, 0,  1, 0, 0, 0, 1);
        vecs[13] = mk(0, 1, 0,  0, 1, 0, 0, 1);  // return to level 0
        vecs[14] = mk(0, 0, 0,  0, 1, 0, 0, 1);
        vecs[15] = mk(0, 0, 0,  0, 0, 0, 0, 1);
        vecs[16] = mk(1, 1, 0,  0, 0, 0, 1, 1);  // both high: no request, conflict
        vecs[17] = mk(0, 0, 0,  0, 0, 0, 0, 1);
        vecs[18] = mk(1, 0, 0,  1, 1, 0, 0, 1);  // reset during hold with pending
        vecs[19] = mk(0, 1, 0,  1, 1, 1, 0, 1);
        vecs[20] = mk(0, 0, 1,  0, 0, 0, 0, 0);
        vecs[21] = mk(0, 1, 0,  0, 0, 0, 0, 0);  // same-level request ignored
        vecs[22] = mk(1, 0, 0,  1, 1, 0, 0, 0);  // long set pulse
        vecs[23] = mk(1, 0, 0,  1, 1, 1, 0, 0);
        vecs[24] = mk(1, 0, 0,  1, 0, 0, 0, 1);

        for (int i = 0; i < NVEC; i++) begin
            a_set = vecs[i].set;
            a_clr = vecs[i].clr;
            reset = vecs[i].rst;
            tick();
            check($sformatf("v%0d conditioned", i), 32'(a_cond), 32'(vecs[i].cond));
            check($sformatf("v%0d busy", i),        32'(a_busy), 32'(vecs[i].busy));
            check($sformatf("v%0d pendingvalid", i), 32'(a_pend), 32'(vecs[i].pend));
            check($sformatf("v%0d conflict", i),    32'(a_conf), 32'(vecs[i].conf));
`ifdef OUTCOND_DROPCOUNT_EN
            check($sformatf("v%0d droppedcount", i), 32'(a_drop), 32'(vecs[i].drop));
`endif
        end
        a_set = 1'b0;
        a_clr = 1'b0;
        reset = 1'b0;

        // holdtime=1: alternating requests toggle the output every cycle, one cycle behind
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("b reset conditioned", 32'(b_cond), 32'd0);
        check("b reset busy", 32'(b_busy), 32'd0);
        for (int i = 0; i < 10; i++) begin
            b_set = (i % 2 == 0);
            b_clr = (i % 2 != 0);
            tick();
            check($sformatf("b toggle%0d conditioned", i), 32'(b_cond), (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("b toggle%0d busy", i), 32'(b_busy), 32'd1);
            check($sformatf("b toggle%0d pendingvalid", i), 32'(b_pend), 32'd0);
        end
        b_set = 1'b0;
        b_clr = 1'b0;
        tick();
        check("b final busy", 32'(b_busy), 32'd0);
        check("b final conditioned", 32'(b_cond), 32'd0);
`ifdef OUTCOND_DROPCOUNT_EN
        check("b droppedcount", 32'(b_drop), 32'd0);

        // holdtime=4, dropwidth=2: repeated overwrites saturate the drop counter at 3
        reset = 1'b1;
        tick();
        reset = 1'b0;
        c_set = 1'b1;
        tick();
        c_set = 1'b0;
        check("c set conditioned", 32'(c_cond), 32'd1);
        c_clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("c drop%0d", i), 32'(c_drop), 32'(i));
        end
        tick();
        check("c expiry conditioned", 32'(c_cond), 32'd0);
        check("c expiry droppedcount", 32'(c_drop), 32'd3);
        tick();
        tick();
        c_clr = 1'b0;
        check("c saturated droppedcount", 32'(c_drop), 32'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
